// File: rtl/obc_dft_pkg.sv
// Shared constants and state type for the OBC-based 16-point DFT bin datapath.
package obc_dft_pkg;

  localparam int unsigned N_PTS = 16;
  localparam int unsigned ROM_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } da_state_t;

endpackage

// File: rtl/obc_bitplane_mux.sv
// Selects bit-plane bit_cnt from the 16 captured samples and raises the
// combiner sign-inversion flag on the MSB plane.
module obc_bitplane_mux
  import obc_dft_pkg::*;
#(
  parameter int unsigned B     = 16,
  parameter int unsigned CNT_W = $clog2(B)
) (
  input  logic [N_PTS*B-1:0] samples,
  input  logic [CNT_W-1:0]   bit_cnt,
  input  logic               enable,
  output logic [N_PTS-1:0]   x_bits,
  output logic               m
);

  localparam logic [CNT_W-1:0] LAST_PLANE = CNT_W'(B - 1);

  always_comb begin
    x_bits = '0;
    m      = 1'b0;
    if (enable) begin
      for (int i = 0; i < N_PTS; i++) begin
        x_bits[i] = samples[i*B + int'(bit_cnt)];
      end
      m = (bit_cnt == LAST_PLANE);
    end
  end

endmodule

// File: rtl/obc_da_sequencer.sv
// Bit-serial sequencer and shift-accumulator for one OBC DFT bin.
// Define OBC_DA_OFFSET_EN to preload the accumulator with OFFSET_INIT on acceptance.
module obc_da_sequencer
  import obc_dft_pkg::*;
#(
  parameter int unsigned             B           = 16,
  parameter int unsigned             ACC_W       = 32 + B,
  parameter logic signed [ACC_W-1:0] OFFSET_INIT = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_PTS*B-1:0] in_data,
  output logic [N_PTS-1:0]   x_bits,
  output logic               m,
  input  logic [ROM_W-1:0]   rom_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data
);

  localparam int unsigned      CNT_W    = $clog2(B);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(B - 1);

`ifdef OBC_DA_OFFSET_EN
  localparam logic [ACC_W-1:0] ACC_PRELOAD = OFFSET_INIT;
`else
  // Offset correction is applied downstream; the parameter is intentionally unused.
  localparam logic [ACC_W-1:0] ACC_PRELOAD = '0;
  logic unused_offset;
  assign unused_offset = ^OFFSET_INIT;
`endif

  da_state_t           state_q, state_d;
  logic [N_PTS*B-1:0]  samples_q, samples_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    rom_ext;
  logic [ACC_W-1:0]    addend;

  obc_bitplane_mux #(
    .B     (B),
    .CNT_W (CNT_W)
  ) u_bitplane_mux (
    .samples (samples_q),
    .bit_cnt (bit_cnt_q),
    .enable  (state_q == RUN),
    .x_bits  (x_bits),
    .m       (m)
  );

  // Every plane carries a positive weight; the MSB negation happens in the combiner.
  assign rom_ext = {{(ACC_W - ROM_W){rom_in[ROM_W-1]}}, rom_in};
  assign addend  = rom_ext << bit_cnt_q;

  always_comb begin
    state_d   = state_q;
    samples_d = samples_q;
    bit_cnt_d = bit_cnt_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          samples_d = in_data;
          bit_cnt_d = '0;
          acc_d     = ACC_PRELOAD;
          state_d   = RUN;
        end
      end
      RUN: begin
        acc_d     = acc_q + addend;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      samples_q <= '0;
      bit_cnt_q <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      samples_q <= samples_d;
      bit_cnt_q <= bit_cnt_d;
      acc_q     <= acc_d;
    end
  end

  assign out_data = acc_q;

endmodule

// File: tb/tb_obc_da_sequencer.sv
// Self-checking bench for obc_da_sequencer: vector table, corner-case sequences
// and randomized blocks against a dot-product reference model.
`timescale 1ns/1ps
module tb_obc_da_sequencer;
  import obc_dft_pkg::*;

  localparam int unsigned B     = 8;
  localparam int unsigned ACC_W = 32 + B;
  localparam logic signed [ACC_W-1:0] OFFSET_INIT = -100;
`ifdef OBC_DA_OFFSET_EN
  localparam longint OFF = -100;
`else
  localparam longint OFF = 0;
`endif

  localparam int M_COUNT  = 0;
  localparam int M_WEIGHT = 1;
  localparam int M_NEG    = 2;
  localparam int M_DOT    = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [N_PTS*B-1:0] in_data;
  logic [N_PTS-1:0]   x_bits;
  logic               m;
  logic [ROM_W-1:0]   rom_in;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_data;

  int checks = 0;
  int errors = 0;
  int mode   = M_COUNT;
  int w [N_PTS];

  obc_da_sequencer #(
    .B           (B),
    .ACC_W       (ACC_W),
    .OFFSET_INIT (OFFSET_INIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .x_bits    (x_bits),
    .m         (m),
    .rom_in    (rom_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Combiner stubs; M_DOT models a two's-complement DA ROM for weights w.
  always_comb begin
    int s;
    s = 0;
    for (int i = 0; i < N_PTS; i++) begin
      if (x_bits[i]) s += w[i];
    end
    case (mode)
      M_COUNT:  rom_in = 32'd1;
      M_WEIGHT: rom_in = {31'b0, x_bits[0]};
      M_NEG:    rom_in = m ? 32'hFFFF_FFFF : 32'd1;
      default:  rom_in = m ? 32'(-s) : 32'(s);
    endcase
  end

  typedef struct {
    int                 mode;
    logic [N_PTS*B-1:0] data;
    longint             exp;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] wrap(input longint v);
    logic [ACC_W-1:0] t;
    t = ACC_W'(v);
    return 64'(t);
  endfunction

  // Sends one block, waits for the result (bounded), consumes it after `stall` cycles.
  task automatic run_block(input logic [N_PTS*B-1:0] data, input int stall,
                           output logic [ACC_W-1:0] res, output int lat, output int m_mask);
    int n;
    res    = '0;
    lat    = 0;
    m_mask = 0;
    in_data  = data;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    in_data  = ~data;
    lat = 1;
    while (!out_valid && lat < 30) begin
      if (m) m_mask |= (1 << lat);
      step();
      lat++;
    end
    if (!out_valid) return;
    for (int i = 0; i < stall; i++) step();
    res = out_data;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ACC_W-1:0]   res;
    logic [ACC_W-1:0]   held;
    logic [N_PTS*B-1:0] d;
    int lat, mm, h0, h1, n;
    longint exp;

    vecs[0] = '{M_COUNT,  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 255};
    vecs[1] = '{M_COUNT,  128'h0, 255};
    vecs[2] = '{M_WEIGHT, 128'h05, 5};
    vecs[3] = '{M_WEIGHT, 128'h80, 128};
    vecs[4] = '{M_WEIGHT, 128'hFF, 255};
    vecs[5] = '{M_NEG,    128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, -1};
    vecs[6] = '{M_NEG,    128'h0, -1};

    for (int i = 0; i < N_PTS; i++) w[i] = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_x_bits", 64'(x_bits), 64'd0);
    check("reset_m", 64'(m), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 7; v++) begin
      mode = vecs[v].mode;
      run_block(vecs[v].data, v % 3, res, lat, mm);
      check("table_result", 64'(res), wrap(vecs[v].exp + OFF));
      check("table_latency", 64'(lat), 64'(B + 1));
      check("table_m_plane", 64'(mm), 64'(1 << B));
      step();
    end

    // Backpressure: result held, in_ready low, pending block taken after the transfer.
    mode = M_COUNT;
    run_block(128'h0, 0, res, lat, mm);
    in_data = 128'h1234;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    check("bp_out_valid", 64'(out_valid), 64'd1);
    held = out_data;
    check("bp_value", 64'(held), wrap(255 + OFF));
    mode = M_WEIGHT;
    in_data = 128'h05;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("bp_stable", 64'(out_data), 64'(held));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_idle_after_xfer", 64'(in_ready), 64'd1);
    check("bp_valid_dropped", 64'(out_valid), 64'd0);
    step();
    in_valid = 1'b0;
    check("bp_accepted", 64'(in_ready), 64'd0);
    lat = 1;
    while (!out_valid && lat < 30) begin
      step();
      lat++;
    end
    check("bp_second_latency", 64'(lat), 64'(B + 1));
    check("bp_second_result", 64'(out_data), wrap(5 + OFF));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset pulse in RUN cycle 4 aborts the block without residue.
    mode = M_COUNT;
    in_data = '1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_run_in_ready", 64'(in_ready), 64'd1);
    check("rst_run_out_valid", 64'(out_valid), 64'd0);
    check("rst_run_out_data", 64'(out_data), 64'd0);
    check("rst_run_x_bits", 64'(x_bits), 64'd0);
    check("rst_run_m", 64'(m), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    mode = M_WEIGHT;
    run_block(128'h05, 1, res, lat, mm);
    check("rst_next_result", 64'(res), wrap(5 + OFF));
    check("rst_next_latency", 64'(lat), 64'(B + 1));

    // Minimum block period with out_ready tied high.
    mode = M_COUNT;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 128'h77;
    h0 = -1;
    h1 = -1;
    for (int c = 0; c < 40; c++) begin
      if (in_valid && in_ready) begin
        if (h0 < 0) h0 = c;
        else if (h1 < 0) h1 = c;
      end
      step();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) step();
    out_ready = 1'b0;
    check("min_period", 64'(h1 - h0), 64'(B + 2));

    // Randomized blocks against the dot-product model sum(w_i * s_i) + offset.
    mode = M_DOT;
    for (int i = 0; i < N_PTS; i++) w[i] = int'($urandom_range(2000)) - 1000;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N_PTS; i++) d[i*B +: B] = B'($urandom);
      exp = OFF;
      for (int i = 0; i < N_PTS; i++) exp += longint'(w[i]) * longint'($signed(d[i*B +: B]));
      repeat ($urandom_range(3)) step();
      run_block(d, int'($urandom_range(4)), res, lat, mm);
      check("rand_result", 64'(res), wrap(exp));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
